// File: rtl/boreal_ledger_reader.sv
// boreal_ledger_reader: drains 256-bit ledger entries over a 32-bit register bus.
// Optional IDX re-polling on underflow: define BOREAL_LEDGER_READER_POLL_EN.
module boreal_ledger_reader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          ENTRY_WORDS = 8,
    parameter int          ACK_TIMEOUT = 16,
    parameter int          POLL_GAP    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [31:0]               start_idx,
    input  logic [15:0]               count,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                err,
    output logic                      sel,
    output logic                      wr,
    output logic [31:0]               addr,
    output logic [31:0]               wdata,
    input  logic [31:0]               rdata,
    input  logic                      ack,
    output logic                      out_valid,
    output logic [ENTRY_WORDS*32-1:0] out_data,
    output logic [31:0]               out_idx,
    input  logic                      out_ready
);

    localparam int WW = (ENTRY_WORDS > 1) ? $clog2(ENTRY_WORDS) : 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int PW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
    localparam logic [WW-1:0] LAST_WORD = WW'(ENTRY_WORDS - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);
    localparam logic [PW-1:0] GAP_LAST  = PW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RD_IDX,
        S_SET_PTR,
        S_RD_WORD,
        S_EMIT,
        S_POLL
    } state_t;

    state_t          state;
    logic [31:0]     cur;
    logic [15:0]     remaining;
    logic [31:0]     idx_cache;
    logic [WW-1:0]   word_sel;
    logic [TW-1:0]   tmo;
    logic [PW-1:0]   gap;
    logic [31:0]     chk_cur;
    logic [15:0]     chk_rem;

    // Pointer/count the next-entry decision is made on (advanced when leaving EMIT)
    always_comb begin
        chk_cur = cur;
        chk_rem = remaining;
        if (state == S_EMIT) begin
            chk_cur = cur + 32'd1;
            chk_rem = remaining - 16'd1;
        end
    end

    // Sequencer, bus initiator and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 2'd0;
            sel       <= 1'b0;
            wr        <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            cur       <= '0;
            remaining <= '0;
            idx_cache <= '0;
            word_sel  <= '0;
            tmo       <= '0;
            gap       <= '0;
        end else begin
            done <= 1'b0;
            if (sel && !ack) begin
                if (tmo == TMO_LAST) begin
                    sel   <= 1'b0;
                    wr    <= 1'b0;
                    err   <= 2'd1;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end else begin
                    tmo <= tmo + 1'b1;
                end
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start) begin
                            cur       <= start_idx;
                            remaining <= count;
                            busy      <= 1'b1;
                            err       <= 2'd0;
                            state     <= S_CHECK;
                        end
                    end
                    S_CHECK, S_EMIT: begin
                        if (state == S_CHECK || out_ready) begin
                            out_valid <= 1'b0;
                            cur       <= chk_cur;
                            remaining <= chk_rem;
                            if (chk_rem == '0) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                err   <= 2'd0;
                                state <= S_IDLE;
                            end else if (chk_cur < idx_cache) begin
                                state <= S_SET_PTR;
                            end else begin
                                state <= S_RD_IDX;
                            end
                        end
                    end
                    S_RD_IDX: begin
                        if (!sel) begin
                            sel  <= 1'b1;
                            wr   <= 1'b0;
                            addr <= BASE_ADDR;
                            tmo  <= '0;
                        end else begin
                            sel       <= 1'b0;
                            idx_cache <= rdata;
                            if (cur < rdata) begin
                                state <= S_SET_PTR;
                            end else begin
`ifdef BOREAL_LEDGER_READER_POLL_EN
                                gap   <= '0;
                                state <= S_POLL;
`else
                                err   <= 2'd2;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= S_IDLE;
`endif
                            end
                        end
                    end
                    S_SET_PTR: begin
                        if (!sel) begin
                            sel   <= 1'b1;
                            wr    <= 1'b1;
                            addr  <= BASE_ADDR + 32'h4;
                            wdata <= cur;
                            tmo   <= '0;
                        end else begin
                            sel      <= 1'b0;
                            wr       <= 1'b0;
                            word_sel <= '0;
                            state    <= S_RD_WORD;
                        end
                    end
                    S_RD_WORD: begin
                        if (!sel) begin
                            sel  <= 1'b1;
                            wr   <= 1'b0;
                            addr <= BASE_ADDR + 32'h20
                                  + {{(30-WW){1'b0}}, word_sel, 2'b00};
                            tmo  <= '0;
                        end else begin
                            sel <= 1'b0;
                            out_data[{word_sel, 5'b0} +: 32] <= rdata;
                            if (word_sel == LAST_WORD) begin
                                out_valid <= 1'b1;
                                out_idx   <= cur;
                                state     <= S_EMIT;
                            end else begin
                                word_sel <= word_sel + 1'b1;
                            end
                        end
                    end
                    S_POLL: begin
                        if (gap == GAP_LAST) begin
                            state <= S_RD_IDX;
                        end else begin
                            gap <= gap + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_boreal_ledger_reader.sv
// tb_boreal_ledger_reader: directed bench with a ledger register-bus responder.
// Covers normal drain, back-pressure, underflow/poll, ack timeout, reset, count=0.
module tb_boreal_ledger_reader;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [31:0]  start_idx;
    logic [15:0]  count;
    logic         busy;
    logic         done;
    logic [1:0]   err;
    logic         sel;
    logic         wr;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata = '0;
    logic         ack = 1'b0;
    logic         out_valid;
    logic [255:0] out_data;
    logic [31:0]  out_idx;
    logic         out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ledger_idx;
    logic        noack_wr;
    logic        noack_w2;
    int          late_req;
    int          late_seen = 0;
    int          ntx = 0;
    logic [31:0] last_ptr = '0;

    boreal_ledger_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_idx (start_idx),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .sel       (sel),
        .wr        (wr),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ack       (ack),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] e,
                                            input logic [31:0] w);
        return {8'hB0, e[11:0], w[11:0]};
    endfunction

    function automatic logic [255:0] entry_of(input logic [31:0] e);
        logic [255:0] v;
        v = '0;
        for (int w = 0; w < 8; w++) v[w*32 +: 32] = word_of(e, 32'(w));
        return v;
    endfunction

    // Ledger side: acks in the first sel cycle unless told to withhold
    always @(negedge clk) begin
        if (ack) begin
            ack = 1'b0;
        end else if (late_req != late_seen) begin
            late_seen = late_req;
            ack = 1'b1;
        end else if (sel && !rst && !(wr && noack_wr)
                     && !(!wr && noack_w2 && addr == 32'h28)) begin
            ack = 1'b1;
            ntx++;
            if (wr) begin
                if (addr == 32'h4) last_ptr = wdata;
            end else if (addr == 32'h0) begin
                rdata = ledger_idx;
            end else begin
                rdata = word_of(last_ptr, (addr - 32'h20) >> 2);
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!out_valid && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_valid_seen"}, 256'(out_valid), 256'(1));
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done_seen"}, 256'(done), 256'(1));
    endtask

    task automatic check_entry(input string tag, input logic [31:0] e);
        wait_valid(tag);
        chk({tag, "_idx"}, 256'(out_idx), 256'(e));
        chk({tag, "_data"}, out_data, entry_of(e));
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [31:0] si, input logic [15:0] c);
        start_idx = si;
        count = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int tx0;
        int n;
        int k;
        logic seen_valid;
        logic seen_sel;

        rst = 1'b1;
        start = 1'b0;
        start_idx = '0;
        count = '0;
        out_ready = 1'b1;
        ledger_idx = 32'd3;
        noack_wr = 1'b0;
        noack_w2 = 1'b0;
        late_req = 0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_sel", 256'(sel), 256'(0));
        chk("rst_wr", 256'(wr), 256'(0));
        chk("rst_addr", 256'(addr), 256'(0));
        chk("rst_wdata", 256'(wdata), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_err", 256'(err), 256'(0));
        chk("rst_valid", 256'(out_valid), 256'(0));
        chk("rst_data", out_data, 256'(0));
        chk("rst_idx", 256'(out_idx), 256'(0));
        rst = 1'b0;
        @(negedge clk);

        // A: three entries, free-flowing
        tx0 = ntx;
        pulse_start(32'd0, 16'd3);
        chk("a_busy", 256'(busy), 256'(1));
        check_entry("a_e0", 32'd0);
        check_entry("a_e1", 32'd1);
        check_entry("a_e2", 32'd2);
        wait_done("a");
        chk("a_err", 256'(err), 256'(0));
        chk("a_busy_end", 256'(busy), 256'(0));
        chk("a_ntx", 256'(ntx - tx0), 256'(28));
        @(negedge clk);

        // B: back-pressure on entry 1
        pulse_start(32'd0, 16'd3);
        check_entry("b_e0", 32'd0);
        out_ready = 1'b0;
        wait_valid("b_e1");
        for (int i = 0; i < 10; i++) begin
            chk("b_hold_valid", 256'(out_valid), 256'(1));
            chk("b_hold_idx", 256'(out_idx), 256'(1));
            chk("b_hold_data", out_data, entry_of(32'd1));
            chk("b_hold_sel", 256'(sel), 256'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("b_e1_taken", 256'(out_valid), 256'(0));
        check_entry("b_e2", 32'd2);
        wait_done("b");
        chk("b_err", 256'(err), 256'(0));
        @(negedge clk);

        // C: underflow (IDX=2, start 1, count 3)
        do_reset();
        ledger_idx = 32'd2;
        pulse_start(32'd1, 16'd3);
        check_entry("c_e1", 32'd1);
`ifdef BOREAL_LEDGER_READER_POLL_EN
        repeat (60) @(negedge clk);
        chk("c_poll_busy", 256'(busy), 256'(1));
        chk("c_poll_nodone", 256'(done), 256'(0));
        ledger_idx = 32'd4;
        check_entry("c_e2", 32'd2);
        check_entry("c_e3", 32'd3);
        wait_done("c");
        chk("c_err", 256'(err), 256'(0));
`else
        wait_done("c");
        chk("c_err", 256'(err), 256'(2));
        chk("c_novalid", 256'(out_valid), 256'(0));
`endif
        @(negedge clk);

        // D: RD_PTR write never acked
        ledger_idx = 32'd5;
        noack_wr = 1'b1;
        pulse_start(32'd0, 16'd1);
        k = 0;
        while (!sel && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("d_sel_seen", 256'(sel), 256'(1));
        chk("d_wr", 256'(wr), 256'(1));
        chk("d_addr", 256'(addr), 256'(32'h4));
        n = 0;
        seen_valid = 1'b0;
        while (sel && n < 40) begin
            n++;
            if (out_valid) seen_valid = 1'b1;
            @(negedge clk);
        end
        chk("d_sel_cycles", 256'(n), 256'(16));
        chk("d_done", 256'(done), 256'(1));
        chk("d_err", 256'(err), 256'(1));
        chk("d_busy", 256'(busy), 256'(0));
        chk("d_no_valid", 256'(seen_valid), 256'(0));
        noack_wr = 1'b0;
        @(negedge clk);
        chk("d_err_held", 256'(err), 256'(1));

        // E: reset during a pending DATA read, late ack ignored
        noack_w2 = 1'b1;
        ledger_idx = 32'd3;
        pulse_start(32'd0, 16'd1);
        k = 0;
        while (!(sel && addr == 32'h28) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("e_pending_seen", 256'(sel && addr == 32'h28), 256'(1));
        repeat (3) @(negedge clk);
        chk("e_still_pending", 256'(sel), 256'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("e_rst_sel", 256'(sel), 256'(0));
        chk("e_rst_busy", 256'(busy), 256'(0));
        chk("e_rst_valid", 256'(out_valid), 256'(0));
        late_req = late_req + 1;
        repeat (4) @(negedge clk);
        chk("e_late_sel", 256'(sel), 256'(0));
        chk("e_late_busy", 256'(busy), 256'(0));
        chk("e_late_done", 256'(done), 256'(0));
        noack_w2 = 1'b0;
        pulse_start(32'd2, 16'd1);
        check_entry("e_e2", 32'd2);
        wait_done("e");
        chk("e_err", 256'(err), 256'(0));
        @(negedge clk);

        // F: count=0, start held while busy
        seen_sel = 1'b0;
        start_idx = 32'd0;
        count = 16'd0;
        start = 1'b1;
        @(negedge clk);
        if (sel) seen_sel = 1'b1;
        chk("f_busy", 256'(busy), 256'(1));
        count = 16'd5;
        @(negedge clk);
        if (sel) seen_sel = 1'b1;
        chk("f_done", 256'(done), 256'(1));
        chk("f_err", 256'(err), 256'(0));
        chk("f_busy_end", 256'(busy), 256'(0));
        start = 1'b0;
        @(negedge clk);
        if (sel) seen_sel = 1'b1;
        chk("f_ignored", 256'(busy), 256'(0));
        chk("f_no_sel", 256'(seen_sel), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
